// File: rtl/acd_bus_ctrl.sv
// Two-requester controller for a shared bidirectional ACD bus with turnaround,
// write hold and read settle timing, plus round-robin arbitration.
module acd_bus_ctrl #(
  parameter int TURN_CYCLES   = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        acd_dir,
  output logic        acd_oe,
  output logic [15:0] acd_out,
  input  logic [15:0] acd_in
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN_TX = 3'd1,
    DRIVE   = 3'd2,
    TURN_RX = 3'd3,
    SETTLE  = 3'd4,
    SAMPLE  = 3'd5
  } state_t;

  localparam logic [7:0] TURN_M1   = 8'(TURN_CYCLES - 1);
  localparam logic [7:0] HOLD_M1   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        idx_reg, idx_next;
  logic        last_grant_reg, last_grant_next;
  logic        acd_dir_reg, acd_dir_next;
  logic        acd_oe_reg, acd_oe_next;
  logic [15:0] acd_out_reg, acd_out_next;
  logic [1:0]  rsp_valid_reg, rsp_valid_next;
  logic [15:0] rsp_rdata_reg, rsp_rdata_next;

  logic        grant_any;
  logic        grant_idx;
  logic [15:0] wdata_sel [2];

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign grant_idx = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
  assign grant_any = (state_reg == IDLE) && (|req_valid);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = grant_any && (grant_idx == 1'(gi));
      assign wdata_sel[gi] = req_wdata[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    last_grant_next = last_grant_reg;
    acd_dir_next    = acd_dir_reg;
    acd_oe_next     = acd_oe_reg;
    acd_out_next    = acd_out_reg;
    rsp_valid_next  = 2'b00;
    rsp_rdata_next  = rsp_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          idx_next        = grant_idx;
          last_grant_next = grant_idx;
          if (req_write[grant_idx]) begin
            acd_out_next = wdata_sel[grant_idx];
            if (acd_dir_reg && acd_oe_reg) begin
              state_next = DRIVE;
              cnt_next   = HOLD_M1;
            end else begin
              state_next   = TURN_TX;
              acd_dir_next = 1'b1;
              acd_oe_next  = 1'b0;
              cnt_next     = TURN_M1;
            end
          end else if (!acd_dir_reg) begin
            state_next = SETTLE;
            cnt_next   = SETTLE_M1;
          end else begin
            // Release the pins first; direction flips only after the dead time.
            state_next  = TURN_RX;
            acd_oe_next = 1'b0;
            cnt_next    = TURN_M1;
          end
        end
      end
      TURN_TX: begin
        if (cnt_reg == 8'd0) begin
          state_next  = DRIVE;
          acd_oe_next = 1'b1;
          cnt_next    = HOLD_M1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      DRIVE: begin
        if (cnt_reg == 8'd0) begin
          state_next     = IDLE;
          rsp_valid_next = idx_reg ? 2'b10 : 2'b01;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      TURN_RX: begin
        if (cnt_reg == 8'd0) begin
          state_next   = SETTLE;
          acd_dir_next = 1'b0;
          cnt_next     = SETTLE_M1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_reg == 8'd0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SAMPLE: begin
        state_next     = IDLE;
        rsp_rdata_next = acd_in;
        rsp_valid_next = idx_reg ? 2'b10 : 2'b01;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 8'd0;
      idx_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      acd_dir_reg    <= 1'b0;
      acd_oe_reg     <= 1'b0;
      acd_out_reg    <= 16'd0;
      rsp_valid_reg  <= 2'b00;
      rsp_rdata_reg  <= 16'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      last_grant_reg <= last_grant_next;
      acd_dir_reg    <= acd_dir_next;
      acd_oe_reg     <= acd_oe_next;
      acd_out_reg    <= acd_out_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign acd_dir   = acd_dir_reg;
  assign acd_oe    = acd_oe_reg;
  assign acd_out   = acd_out_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_acd_bus_ctrl.sv
// Directed bench for acd_bus_ctrl: expected completions (cycle, requester, data)
// are queued at grant time and matched against rsp_valid as it appears.
module tb_acd_bus_ctrl;

  localparam int TURN   = 4;
  localparam int HOLD   = 2;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        acd_dir;
  logic        acd_oe;
  logic [15:0] acd_out;
  logic [15:0] acd_in = 16'd0;

  acd_bus_ctrl #(
    .TURN_CYCLES  (TURN),
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .acd_dir  (acd_dir),
    .acd_oe   (acd_oe),
    .acd_out  (acd_out),
    .acd_in   (acd_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] rdata;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of bus state, used to predict latency and held read data.
  bit          m_dir = 0;
  bit          m_oe = 0;
  logic [15:0] m_rdata = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input bit wr, input logic [15:0] data, input int gc);
    exp_t e;
    int   lat;
    if (wr) begin
      lat   = HOLD + 1 + ((m_dir && m_oe) ? 0 : TURN);
      m_dir = 1;
      m_oe  = 1;
    end else begin
      lat     = SETTLE + 2 + (m_dir ? TURN : 0);
      m_dir   = 0;
      m_oe    = 0;
      m_rdata = data;
    end
    e.vld   = (idx == 1) ? 2'b10 : 2'b01;
    e.rdata = m_rdata;
    e.at    = gc + lat;
    sb.push_back(e);
  endtask

  task automatic do_op(input int idx, input bit wr, input logic [15:0] data,
                       input bit push, output int gc);
    int n;
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if (!wr) acd_in = data;
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_wdata[idx*16 +: 16] = data;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", {30'd0, req_ready}, {30'd0, oh});
    gc = cyc;
    if (push) push_exp(idx, wr, data, gc);
    $display("op req%0d %s data=%h granted at cycle %0d", idx, wr ? "write" : "read", data, gc);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int   gc;
    int   prev_gc;
    int   n;
    logic [1:0] exp_g;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (acd_oe === 1'b1) check("oe_implies_dir", {31'd0, acd_dir}, 32'd1);
        if (rsp_valid !== 2'b00) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            $display("rsp valid=%b rdata=%h at cycle %0d (expected %b %h @%0d)",
                     rsp_valid, rsp_rdata, cyc, e.vld, e.rdata, e.at);
            check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
            check("rsp_cycle", cyc, e.at);
            check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dir", {31'd0, acd_dir}, 32'd0);
    check("rst_oe", {31'd0, acd_oe}, 32'd0);
    check("rst_out", {16'd0, acd_out}, 32'd0);
    check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_ready", {30'd0, req_ready}, 32'd0);

    // Read from requester 0, bus already in receive direction.
    do_op(0, 1'b0, 16'h1234, 1'b1, gc);
    wait_cyc(gc + 3);
    check("read_dir_low", {31'd0, acd_dir}, 32'd0);
    drain();

    // First write needs a turnaround.
    do_op(1, 1'b1, 16'hAA55, 1'b1, gc);
    wait_cyc(gc + 1);
    check("tx_dir_c1", {31'd0, acd_dir}, 32'd1);
    check("tx_oe_c1", {31'd0, acd_oe}, 32'd0);
    wait_cyc(gc + 4);
    check("tx_oe_c4", {31'd0, acd_oe}, 32'd0);
    wait_cyc(gc + 5);
    check("tx_oe_c5", {31'd0, acd_oe}, 32'd1);
    check("tx_out_c5", {16'd0, acd_out}, 32'h0000AA55);
    wait_cyc(gc + 6);
    check("tx_oe_c6", {31'd0, acd_oe}, 32'd1);
    drain();

    // Same-direction write: no turnaround, pins stay driven.
    do_op(0, 1'b1, 16'h1357, 1'b1, gc);
    wait_cyc(gc + 1);
    check("wr2_oe_c1", {31'd0, acd_oe}, 32'd1);
    check("wr2_out_c1", {16'd0, acd_out}, 32'h00001357);
    drain();
    check("wr2_oe_after", {31'd0, acd_oe}, 32'd1);

    // Write followed by read: release pins, then flip direction.
    do_op(1, 1'b0, 16'h5A5A, 1'b1, gc);
    wait_cyc(gc + 1);
    check("rx_oe_c1", {31'd0, acd_oe}, 32'd0);
    check("rx_dir_c1", {31'd0, acd_dir}, 32'd1);
    wait_cyc(gc + 4);
    check("rx_dir_c4", {31'd0, acd_dir}, 32'd1);
    wait_cyc(gc + 5);
    check("rx_dir_c5", {31'd0, acd_dir}, 32'd0);
    drain();

    // Both requesters continuously valid: grants alternate, back-to-back.
    @(negedge clk);
    acd_in    = 16'hBEEF;
    req_write = 2'b00;
    req_valid = 2'b11;
    #1;
    exp_g   = 2'b01;
    prev_gc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rr_grant", {30'd0, req_ready}, {30'd0, exp_g});
      gc = cyc;
      push_exp((exp_g == 2'b10) ? 1 : 0, 1'b0, 16'hBEEF, gc);
      $display("rr grant %b at cycle %0d", req_ready, gc);
      if (k > 0) check("rr_b2b_cycle", gc, prev_gc + SETTLE + 2);
      prev_gc = gc;
      exp_g   = ~exp_g;
      @(negedge clk);
      #1;
      check("rr_ready_once", {30'd0, req_ready}, 32'd0);
      if (k == 3) req_valid = 2'b00;
    end
    drain();

    // Reset during DRIVE aborts the write without a response.
    do_op(0, 1'b1, 16'hC3C3, 1'b0, gc);
    wait_cyc(gc + 5);
    check("abort_drive_oe", {31'd0, acd_oe}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_oe", {31'd0, acd_oe}, 32'd0);
    check("abort_dir", {31'd0, acd_dir}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    m_dir   = 0;
    m_oe    = 0;
    m_rdata = 16'd0;
    repeat (10) @(negedge clk);

    do_op(1, 1'b1, 16'h0F0F, 1'b1, gc);
    wait_cyc(gc + 5);
    check("post_rst_out", {16'd0, acd_out}, 32'h00000F0F);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acd_bus_ctrl.md
ACD_BUS_CTRL -- requirements
Module: acd_bus_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 4: dead cycles on every bus direction change; legal 1..255.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: cycles a write word is driven; legal 1..255.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 3: cycles between read start and sample; legal 1..255.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  2  per-requester access request (bit i = requester i).
REQ-007 SHALL have port req_write  in  2  per-requester op: 1 write, 0 read.
REQ-008 SHALL have port req_wdata  in  32  write words; [15:0] requester 0, [31:16] requester 1.
REQ-009 SHALL have port req_ready  out  2  one-hot grant/accept; combinational, only in IDLE.
REQ-010 SHALL have port rsp_valid  out  2  registered one-cycle completion pulse per requester.
REQ-011 SHALL have port rsp_rdata  out  16  registered read word; valid with rsp_valid.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port acd_dir  out  1  external transceiver direction; 1 = FPGA drives ACD.
REQ-014 SHALL have port acd_oe  out  1  FPGA tri-state enable for ACD pins.
REQ-015 SHALL have port acd_out  out  16  word driven when acd_oe=1.
REQ-016 SHALL have port acd_in  in  16  ACD pin input, already synchronised externally.

Function
REQ-017 SHALL implement states IDLE, TURN_TX, DRIVE, TURN_RX, SETTLE, SAMPLE with one 8-bit down-counter.
REQ-018 SHALL arbitrate in IDLE round-robin: single valid wins; both valid -> requester not granted last; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-019 SHALL, on grant, latch op and requester index, and load acd_out with granted wdata if write.
REQ-020 SHALL, after a write grant: go DRIVE if acd_dir=1 and acd_oe=1, else TURN_TX.
REQ-021 SHALL, after a read grant: go SETTLE if acd_dir=0, else TURN_RX.
REQ-022 TURN_TX: acd_dir=1 from entry, acd_oe=0, lasts TURN_CYCLES, then DRIVE with acd_oe=1 from entry.
REQ-023 TURN_RX: acd_oe=0 from entry, acd_dir stays 1 for TURN_CYCLES, then SETTLE with acd_dir=0 from entry.
REQ-024 DRIVE lasts HOLD_CYCLES; rsp_valid[i] visible the cycle after the last DRIVE cycle; state IDLE that same cycle.
REQ-025 SETTLE lasts SETTLE_CYCLES, then one SAMPLE cycle registering acd_in into rsp_rdata; rsp_valid[i] visible next cycle with state IDLE.
REQ-026 Latency from grant cycle C to rsp_valid: write HOLD_CYCLES+1, read SETTLE_CYCLES+2; add TURN_CYCLES when a direction change is needed.
REQ-027 Bus direction and acd_oe SHALL persist after an op; no turnaround between same-direction ops.
REQ-028 Invariant: acd_oe=1 implies acd_dir=1; acd_dir SHALL never change while acd_oe=1 or before acd_oe has been 0 for TURN_CYCLES.
REQ-029 A new grant SHALL be possible in the same cycle rsp_valid is high (back-to-back ops).
REQ-030 Requesters SHALL hold req_valid/req_write/req_wdata until req_ready; withdrawal before grant is legal and ignored.
REQ-031 rsp_rdata SHALL hold its last value until the next SAMPLE; writes do not alter it.

Reset
REQ-032 On rst: state IDLE, acd_dir=0, acd_oe=0, acd_out=0, rsp_valid=0, rsp_rdata=0, busy=0, counter=0, last-grant=1.
REQ-033 rst mid-operation SHALL abort immediately with no rsp_valid for the aborted op; acd_oe drops asynchronously.

Verification
REQ-034 Reset, read req0, acd_in=16'h1234, defaults -> rsp_valid[0] at C+5, rsp_rdata=16'h1234, acd_dir stays 0.
REQ-035 Write req1 wdata 16'hAA55 from reset -> acd_dir=1 at C+1, acd_oe=1 at C+5..C+6 with acd_out=16'hAA55, rsp_valid[1] at C+7.
REQ-036 Second write immediately after -> no TURN_TX, rsp_valid at C+3, acd_oe never drops.
REQ-037 Write then read -> acd_oe falls first cycle of TURN_RX, acd_dir falls 4 cycles later, rsp_valid at C+9.
REQ-038 Both requesters valid continuously -> grants alternate 0,1,0,1; each ready exactly one cycle per op.
REQ-039 rst asserted during DRIVE -> acd_oe=0, acd_dir=0 immediately, no rsp_valid, next request served normally.
